// File: rtl/time_field_editor.sv
// time_field_editor: edits a BCD hh:mm:ss value one field at a time.
// Captures hh_in/mm_in/ss_in when edit mode starts, applies single-step BCD
// increments/decrements to the field chosen by dir, and pulses commit when
// edit mode ends. Fields wrap individually; nothing carries between fields.
module time_field_editor #(
  parameter logic [7:0] HOUR_MAX = 8'h23,
  parameter logic [7:0] MS_MAX   = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] dir,
  input  logic       up,
  input  logic       down,
  input  logic [7:0] hh_in,
  input  logic [7:0] mm_in,
  input  logic [7:0] ss_in,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       changed,
  output logic       commit
);

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] hh_r;
  logic [7:0] mm_r;
  logic [7:0] ss_r;
  logic       changed_r;
  logic       commit_r;
  logic [7:0] hh_next_s;
  logic [7:0] mm_next_s;
  logic [7:0] ss_next_s;
  logic       changed_next_s;
  logic       commit_next_s;
  logic       single_op_s;

  // A value is only worth stepping if both nibbles are decimal and it lies
  // within the field's range; anything else snaps to a boundary on first edit.
  function automatic logic bcd_legal(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // BCD +1 with wrap from max to zero; illegal input snaps to zero.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (!bcd_legal(v, max) || (v == max)) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD -1 with wrap from zero to max; illegal input snaps to max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (!bcd_legal(v, max) || (v == 8'h00)) begin
      r = max;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // One step in the direction of the pressed button.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max,
                                          input logic inc);
    logic [7:0] r;
    if (inc) begin
      r = bcd_inc(v, max);
    end else begin
      r = bcd_dec(v, max);
    end
    return r;
  endfunction

  // Exactly one button pressed; both together cancel out.
  assign single_op_s = up ^ down;

  // Next-state, next-field and pulse decode for the IDLE/EDIT machine.
  always_comb begin
    state_next_s   = state_r;
    hh_next_s      = hh_r;
    mm_next_s      = mm_r;
    ss_next_s      = ss_r;
    changed_next_s = 1'b0;
    commit_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          // Entry edge: capture the live time, ignore any button on this edge.
          state_next_s = EDIT;
          hh_next_s    = hh_in;
          mm_next_s    = mm_in;
          ss_next_s    = ss_in;
        end else begin
          state_next_s = IDLE;
        end
      end
      EDIT: begin
        if (!en) begin
          state_next_s  = IDLE;
          commit_next_s = 1'b1;
        end else if (single_op_s) begin
          case (dir)
            2'b00: begin
              hh_next_s      = bcd_step(hh_r, HOUR_MAX, up);
              changed_next_s = 1'b1;
            end
            2'b01: begin
              mm_next_s      = bcd_step(mm_r, MS_MAX, up);
              changed_next_s = 1'b1;
            end
            2'b10: begin
              ss_next_s      = bcd_step(ss_r, MS_MAX, up);
              changed_next_s = 1'b1;
            end
            default: begin
              changed_next_s = 1'b0;
            end
          endcase
        end else begin
          changed_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, field and pulse registers; reset clears everything, so a reset
  // mid-edit never produces a commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      hh_r      <= 8'h00;
      mm_r      <= 8'h00;
      ss_r      <= 8'h00;
      changed_r <= 1'b0;
      commit_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      hh_r      <= hh_next_s;
      mm_r      <= mm_next_s;
      ss_r      <= ss_next_s;
      changed_r <= changed_next_s;
      commit_r  <= commit_next_s;
    end
  end

  assign hh      = hh_r;
  assign mm      = mm_r;
  assign ss      = ss_r;
  assign changed = changed_r;
  assign commit  = commit_r;

endmodule

// File: tb/tb_time_field_editor.sv
// Self-checking bench for time_field_editor: each scenario task drives
// per-cycle stimulus, queues the expected outputs, captures observed outputs
// one edge later and compares the two queues inline.
module tb_time_field_editor;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] dir;
  logic       up;
  logic       down;
  logic [7:0] hh_in;
  logic [7:0] mm_in;
  logic [7:0] ss_in;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       changed;
  logic       commit;

  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  int          n_run;
  int          n_fail;

  time_field_editor #(
    .HOUR_MAX(8'h23),
    .MS_MAX  (8'h59)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .dir    (dir),
    .up     (up),
    .down   (down),
    .hh_in  (hh_in),
    .mm_in  (mm_in),
    .ss_in  (ss_in),
    .hh     (hh),
    .mm     (mm),
    .ss     (ss),
    .changed(changed),
    .commit (commit)
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs at a negedge, queue the expected result, and
  // capture the DUT outputs at the next negedge (after the sampling posedge).
  task automatic drive(input logic i_en, input logic [1:0] i_dir, input logic i_up,
                       input logic i_dn, input logic [7:0] x_hh, input logic [7:0] x_mm,
                       input logic [7:0] x_ss, input logic x_ch, input logic x_cm);
    en   = i_en;
    dir  = i_dir;
    up   = i_up;
    down = i_dn;
    exp_q.push_back({x_hh, x_mm, x_ss, x_ch, x_cm});
    @(negedge clk);
    obs_q.push_back({hh, mm, ss, changed, commit});
  endtask

  task automatic test_reset();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    hh_in = 8'h12; mm_in = 8'h34; ss_in = 8'h56;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_entry();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    hh_in = 8'h23; mm_in = 8'h59; ss_in = 8'h58;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL entry step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h59, 8'h58, 1'b1, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h23, 8'h00, 8'h58, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_conflict();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    drive(1'b1, 2'b01, 1'b1, 1'b1, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b1, 1'b0, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL conflict step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    drive(1'b1, 2'b10, 1'b1, 1'b0, 8'h23, 8'h59, 8'h59, 1'b1, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 8'h23, 8'h59, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 8'h23, 8'h59, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h23, 8'h58, 8'h01, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_exit();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    drive(1'b0, 2'b10, 1'b1, 1'b0, 8'h23, 8'h58, 8'h01, 1'b0, 1'b1);
    hh_in = 8'h11;
    drive(1'b0, 2'b10, 1'b1, 1'b0, 8'h23, 8'h58, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 8'h23, 8'h58, 8'h01, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL exit step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_bcd_carry();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    hh_in = 8'h19; mm_in = 8'h00; ss_in = 8'h09;
    drive(1'b1, 2'b10, 1'b0, 1'b0, 8'h19, 8'h00, 8'h09, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 8'h19, 8'h00, 8'h10, 1'b1, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h19, 8'h00, 8'h09, 1'b1, 1'b0);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h20, 8'h00, 8'h09, 1'b1, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 8'h19, 8'h00, 8'h09, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h19, 8'h59, 8'h09, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h19, 8'h59, 8'h09, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h19, 8'h59, 8'h09, 1'b0, 1'b0);
    hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h00;
    drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'h59, 1'b1, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 8'h23, 8'h00, 8'h59, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bcd_carry step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h23, 8'h00, 8'h59, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h23, 8'h00, 8'h59, 1'b0, 1'b0);
    hh_in = 8'h2A; mm_in = 8'h7F; ss_in = 8'hF0;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h2A, 8'h7F, 8'hF0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h7F, 8'hF0, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h00, 8'h59, 8'hF0, 1'b1, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 8'h59, 8'h00, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_edit();
    logic [25:0] e;
    logic [25:0] o;
    int          k;
    hh_in = 8'h05; mm_in = 8'h06; ss_in = 8'h07;
    // Asynchronous clear: outputs must drop before any clock edge.
    reset = 1'b0;
    #1;
    n_run++;
    if ({hh, mm, ss, changed, commit} !== 26'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h:%h:%h ch=%b cm=%b, expected 00:00:00 ch=0 cm=0",
               hh, mm, ss, changed, commit);
    end
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 8'h05, 8'h06, 8'h07, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 8'h05, 8'h06, 8'h08, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h05, 8'h06, 8'h08, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h05, 8'h06, 8'h08, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_edit step %0d: got %h:%h:%h ch=%b cm=%b, expected %h:%h:%h ch=%b cm=%b",
                 k, o[25:18], o[17:10], o[9:2], o[1], o[0], e[25:18], e[17:10], e[9:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  // Scenario sequence.
  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    en     = 1'b0;
    dir    = 2'b00;
    up     = 1'b0;
    down   = 1'b0;
    hh_in  = 8'h00;
    mm_in  = 8'h00;
    ss_in  = 8'h00;
    @(negedge clk);
    test_reset();
    test_entry();
    test_wrap();
    test_conflict();
    test_back_to_back();
    test_exit();
    test_bcd_carry();
    test_illegal();
    test_reset_mid_edit();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
